// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Each multiply has an ISSUE cycle (start pulse) and a WAIT phase with a timeout.
module mod_exp_ctrl #(
  parameter int unsigned W   = 256,
  parameter int unsigned TMO = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] N,
  input  logic [W-1:0] r2,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic [W-1:0] mul_n,
  output logic         mul_start_n,
  input  logic [W-1:0] mul_out,
  input  logic         mul_done,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err
);

  localparam int unsigned IW   = $clog2(W);
  localparam int unsigned IdxW = IW + 1;
  localparam int unsigned CW   = $clog2(TMO + 1);

  localparam logic [IdxW-1:0] IdxTop  = IdxW'(W - 1);
  localparam logic [CW-1:0]   TmoLast = CW'(TMO - 1);
  localparam logic [W-1:0]    One     = W'(1);

  typedef enum logic [2:0] {
    StIdle, StPreX, StPreAcc, StSqr, StMul, StPost, StDone
  } state_e;

  typedef enum logic {PhIssue, PhWait} phase_e;

  state_e          r_state, w_state_d;
  phase_e          r_phase, w_phase_d;
  logic [W-1:0]    r_base, w_base_d;
  logic [W-1:0]    r_exp, w_exp_d;
  logic [W-1:0]    r_n, w_n_d;
  logic [W-1:0]    r_r2, w_r2_d;
  logic [W-1:0]    r_xm, w_xm_d;
  logic [W-1:0]    r_acc, w_acc_d;
  logic [W-1:0]    r_result, w_result_d;
  logic [IdxW-1:0] r_idx, w_idx_d;
  logic [CW-1:0]   r_wcnt, w_wcnt_d;
  logic            r_err, w_err_d;

  logic w_exp_bit;
  logic w_done_ok;

  assign w_exp_bit = r_exp[r_idx[IW-1:0]];
  // A done seen on the first WAIT cycle may be left over from the previous multiply.
  assign w_done_ok = mul_done && (r_wcnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_phase  <= PhIssue;
      r_base   <= '0;
      r_exp    <= '0;
      r_n      <= '0;
      r_r2     <= '0;
      r_xm     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_wcnt   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_phase  <= w_phase_d;
      r_base   <= w_base_d;
      r_exp    <= w_exp_d;
      r_n      <= w_n_d;
      r_r2     <= w_r2_d;
      r_xm     <= w_xm_d;
      r_acc    <= w_acc_d;
      r_result <= w_result_d;
      r_idx    <= w_idx_d;
      r_wcnt   <= w_wcnt_d;
      r_err    <= w_err_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_phase_d  = r_phase;
    w_base_d   = r_base;
    w_exp_d    = r_exp;
    w_n_d      = r_n;
    w_r2_d     = r_r2;
    w_xm_d     = r_xm;
    w_acc_d    = r_acc;
    w_result_d = r_result;
    w_idx_d    = r_idx;
    w_wcnt_d   = r_wcnt;
    w_err_d    = 1'b0;

    case (r_state)
      StIdle: begin
        if (go) begin
          if (N[0]) begin
            w_base_d  = base;
            w_exp_d   = exp;
            w_n_d     = N;
            w_r2_d    = r2;
            w_idx_d   = IdxTop;
            w_wcnt_d  = '0;
            w_phase_d = PhIssue;
            w_state_d = StPreX;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StDone: w_state_d = StIdle;
      default: begin
        if (r_phase == PhIssue) begin
          w_phase_d = PhWait;
          w_wcnt_d  = '0;
        end else if (w_done_ok) begin
          w_phase_d = PhIssue;
          w_wcnt_d  = '0;
          case (r_state)
            StPreX: begin
              w_xm_d    = mul_out;
              w_state_d = StPreAcc;
            end
            StPreAcc: begin
              w_acc_d   = mul_out;
              w_state_d = StSqr;
            end
            StSqr: begin
              w_acc_d = mul_out;
              if (w_exp_bit) begin
                w_state_d = StMul;
              end else begin
                w_idx_d   = r_idx - 1'b1;
                w_state_d = (r_idx == '0) ? StPost : StSqr;
              end
            end
            StMul: begin
              w_acc_d   = mul_out;
              w_idx_d   = r_idx - 1'b1;
              w_state_d = (r_idx == '0) ? StPost : StSqr;
            end
            StPost: begin
              w_result_d = mul_out;
              w_state_d  = StDone;
            end
            default: w_state_d = StIdle;
          endcase
        end else if (r_wcnt == TmoLast) begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
          w_phase_d = PhIssue;
          w_wcnt_d  = '0;
        end else begin
          w_wcnt_d = r_wcnt + 1'b1;
        end
      end
    endcase
  end

  // Operands are a pure function of state, so they stay put for the whole WAIT.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    mul_n = '0;
    case (r_state)
      StPreX: begin
        mul_a = r_base;
        mul_b = r_r2;
        mul_n = r_n;
      end
      StPreAcc: begin
        mul_a = One;
        mul_b = r_r2;
        mul_n = r_n;
      end
      StSqr: begin
        mul_a = r_acc;
        mul_b = r_acc;
        mul_n = r_n;
      end
      StMul: begin
        mul_a = r_acc;
        mul_b = r_xm;
        mul_n = r_n;
      end
      StPost: begin
        mul_a = r_acc;
        mul_b = One;
        mul_n = r_n;
      end
      default: ;
    endcase
  end

  assign busy         = (r_state != StIdle) && (r_state != StDone);
  assign mul_start_n  = !(busy && (r_phase == PhIssue));
  assign result       = r_result;
  assign result_valid = (r_state == StDone);
  assign err          = r_err;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Randomised bench for mod_exp_ctrl: behavioural Montgomery multiplier plus a plain
// modular-power reference; directed cases for bad modulus, timeout and mid-run reset.
module tb_mod_exp_ctrl;

  localparam int unsigned W   = 12;
  localparam int unsigned TMO = 512;
  localparam int unsigned LAT = 258;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] in_base = '0;
  logic [W-1:0] in_exp = '0;
  logic [W-1:0] in_n = '0;
  logic [W-1:0] in_r2 = '0;
  logic [W-1:0] mul_a, mul_b, mul_n;
  logic         mul_start_n;
  logic [W-1:0] mul_out = '0;
  logic         mul_done = 1'b0;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .base(in_base), .exp(in_exp), .N(in_n), .r2(in_r2),
    .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n), .mul_start_n(mul_start_n),
    .mul_out(mul_out), .mul_done(mul_done),
    .busy(busy), .result(result), .result_valid(result_valid), .err(err)
  );

  // MM(x,y) = x*y*2^-W mod n by bitwise halving.
  function automatic logic [W-1:0] mm(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic [W-1:0] n);
    longint t;
    t = longint'(x) * longint'(y);
    for (int i = 0; i < int'(W); i++) begin
      if (t[0]) t = t + longint'(n);
      t = t >>> 1;
    end
    return W'(t % longint'(n));
  endfunction

  // Multiplier model: records every launch, answers after lat cycles, holds done for hold cycles.
  int unsigned  lat = LAT;
  int unsigned  hold = 1;
  bit           no_done = 1'b0;
  int           issue_cnt = 0;
  int           stab_bad = 0;
  logic [W-1:0] obs_a [1024];
  logic [W-1:0] obs_b [1024];
  logic [W-1:0] obs_n [1024];
  bit           pend = 1'b0;
  int unsigned  cnt = 0;
  int unsigned  hold_cnt = 0;
  logic [W-1:0] la, lb, ln;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      hold_cnt = 0;
      mul_done = 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) mul_done = 1'b0;
      end
      if (pend) begin
        if (mul_a !== la || mul_b !== lb || mul_n !== ln) stab_bad++;
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          if (!no_done) begin
            mul_out = mm(la, lb, ln);
            mul_done = 1'b1;
            hold_cnt = hold;
          end
        end
      end
      if (mul_start_n === 1'b0) begin
        obs_a[issue_cnt % 1024] = mul_a;
        obs_b[issue_cnt % 1024] = mul_b;
        obs_n[issue_cnt % 1024] = mul_n;
        issue_cnt++;
        la = mul_a;
        lb = mul_b;
        ln = mul_n;
        pend = 1'b1;
        cnt = lat;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic go_pulse(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                          input logic [W-1:0] r);
    @(posedge clk);
    #1;
    in_base = b;
    in_exp  = e;
    in_n    = n;
    in_r2   = r;
    go      = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  function automatic logic [W-1:0] calc_r2(input int n);
    return W'((longint'(1) << (2 * W)) % longint'(n));
  endfunction

  task automatic run_op(input int b, input int e, input int n, input int unsigned l,
                        input int unsigned h, input bit junk_go, output logic [W-1:0] res);
    logic [W-1:0] bv, ev, nv, r2v, xm, acc;
    logic [W-1:0] ea[$];
    logic [W-1:0] eb[$];
    longint       ref_r;
    int           b0, rv, er, cyc, budget, nops;
    bit           seen;
    bv  = W'(b);
    ev  = W'(e);
    nv  = W'(n);
    r2v = calc_r2(n);
    ref_r = 1 % longint'(n);
    for (int k = 0; k < e; k++) ref_r = (ref_r * longint'(b)) % longint'(n);
    ea.push_back(bv);
    eb.push_back(r2v);
    xm = mm(bv, r2v, nv);
    ea.push_back(W'(1));
    eb.push_back(r2v);
    acc = mm(W'(1), r2v, nv);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      ea.push_back(acc);
      eb.push_back(acc);
      acc = mm(acc, acc, nv);
      if (ev[i]) begin
        ea.push_back(acc);
        eb.push_back(xm);
        acc = mm(acc, xm, nv);
      end
    end
    ea.push_back(acc);
    eb.push_back(W'(1));
    lat  = l;
    hold = h;
    b0   = issue_cnt;
    go_pulse(bv, ev, nv, r2v);
    @(negedge clk);
    check("busy_after_go", 64'(busy), 64'(1));
    check("first_issue", 64'(mul_start_n), 64'(0));
    rv = 0;
    er = 0;
    cyc = 0;
    seen = 1'b0;
    budget = ea.size() * int'(l + h + 6) + 40;
    while (cyc < budget && !seen) begin
      if (junk_go && (cyc == 50 || cyc == 400 || cyc == 3000)) begin
        in_base = ~bv;
        in_exp  = ~ev;
        in_n    = W'(n + 2);
        go      = 1'b1;
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (err) er++;
      if (result_valid) begin
        rv++;
        seen = 1'b1;
        check("busy_at_valid", 64'(busy), 64'(0));
      end
    end
    go = 1'b0;
    check("completed", 64'(seen), 64'(1));
    repeat (3) begin
      @(negedge clk);
      if (result_valid) rv++;
      if (err) er++;
    end
    nops = issue_cnt - b0;
    check("result", 64'(result), 64'(ref_r));
    check("valid_pulses", 64'(rv), 64'(1));
    check("err_pulses", 64'(er), 64'(0));
    check("mul_count", 64'(nops), 64'(int'(W) + 3 + $countones(ev)));
    for (int k = 0; k < ea.size() && k < nops; k++) begin
      check("op_a", 64'(obs_a[(b0 + k) % 1024]), 64'(ea[k]));
      check("op_b", 64'(obs_b[(b0 + k) % 1024]), 64'(eb[k]));
      check("op_n", 64'(obs_n[(b0 + k) % 1024]), 64'(nv));
    end
    res = result;
  endtask

  initial begin
    logic [W-1:0] r;
    int b0, er, bz, st, c_iss, c_err;
    int nn, bb, ee;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_valid", 64'(result_valid), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_start_n", 64'(mul_start_n), 64'(1));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    rst_n = 1'b1;

    run_op(3, 5, 7, LAT, 1, 1'b0, r);
    check("lit_3_5_7", 64'(r), 64'(5));
    run_op(9, 0, 11, LAT, 1, 1'b0, r);
    check("lit_9_0_11", 64'(r), 64'(1));
    run_op(3, 5, 7, LAT, 1, 1'b1, r);
    check("lit_go_while_busy", 64'(r), 64'(5));

    // Even modulus: one err cycle, nothing launched, result untouched.
    b0 = issue_cnt;
    go_pulse(W'(5), W'(3), W'(10), W'(0));
    er = 0;
    bz = 0;
    st = 0;
    repeat (10) begin
      @(negedge clk);
      if (err) er++;
      if (busy) bz++;
      if (!mul_start_n) st++;
    end
    check("even_n_err", 64'(er), 64'(1));
    check("even_n_busy", 64'(bz), 64'(0));
    check("even_n_starts", 64'(st), 64'(0));
    check("even_n_issues", 64'(issue_cnt - b0), 64'(0));
    check("even_n_result", 64'(result), 64'(5));

    // Asynchronous reset in the first SQR wait.
    lat = LAT;
    hold = 1;
    b0 = issue_cnt;
    go_pulse(W'(9), W'(7), W'(11), calc_r2(11));
    for (int c = 0; c < 3000 && (issue_cnt - b0) < 3; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("sqr_wait_issues", 64'(issue_cnt - b0), 64'(3));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_result", 64'(result), 64'(0));
    check("mid_rst_valid", 64'(result_valid), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    check("mid_rst_start_n", 64'(mul_start_n), 64'(1));
    check("mid_rst_ops", 64'({mul_a, mul_b, mul_n}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(2, 10, 1009, LAT, 1, 1'b0, r);
    check("lit_2_10_1009", 64'(r), 64'(15));

    // Multiplier never answers: timeout counted from the first WAIT cycle.
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    b0 = issue_cnt;
    go_pulse(W'(3), W'(5), W'(7), calc_r2(7));
    c_iss = -1;
    c_err = -1;
    er = 0;
    bz = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (!mul_start_n && c_iss < 0) c_iss = c;
      if (err) begin
        er++;
        if (c_err < 0) begin
          c_err = c;
          bz = int'(busy);
        end
      end
    end
    check("tmo_delay", 64'(c_err - (c_iss + 1)), 64'(TMO));
    check("tmo_err_pulses", 64'(er), 64'(1));
    check("tmo_busy", 64'(bz), 64'(0));
    check("tmo_busy_end", 64'(busy), 64'(0));
    check("tmo_result", 64'(result), 64'(0));
    check("tmo_issues", 64'(issue_cnt - b0), 64'(1));
    no_done = 1'b0;

    for (int i = 0; i < 8; i++) begin
      nn = int'($urandom_range(4095, 3)) | 1;
      bb = int'($urandom_range(nn - 1, 0));
      ee = int'($urandom_range(4095, 0));
      run_op(bb, ee, nn, $urandom_range(12, 3), $urandom_range(3, 1), 1'b0, r);
    end

    check("operand_stability", 64'(stab_bad), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter W, default 256: operand width in bits.
REQ-002 SHALL have parameter TMO, default 512: multiply-timeout limit in clk cycles.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is posedge-triggered.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port go, input, 1: request pulse, sampled only in IDLE.
REQ-006 SHALL have ports base, exp, N, r2, input, W each: base, exponent, odd modulus, and R^2 mod N with R = 2^W.
REQ-007 SHALL have ports mul_a, mul_b, mul_n, output, W each: operands to the external Montgomery multiplier.
REQ-008 SHALL have port mul_start_n, output, 1: active-low launch pulse to the multiplier.
REQ-009 SHALL have ports mul_out, input, W, and mul_done, input, 1: multiplier result and completion flag, which is level-sampled.
REQ-010 SHALL have port busy, output, 1: an exponentiation is in progress.
REQ-011 SHALL have port result, output, W: base^exp mod N.
REQ-012 SHALL have port result_valid, output, 1: one-cycle pulse when result updates.
REQ-013 SHALL have port err, output, 1: one-cycle error pulse.

Function
REQ-014 SHALL compute base^exp mod N by left-to-right square-and-multiply, where MM(x,y) = x*y*R^-1 mod N is performed by the external multiplier.
REQ-015 SHALL follow this sequence:
- PRE_X: xm = MM(base, r2).
- PRE_ACC: acc = MM(1, r2).
- For i = W-1 down to 0: SQR acc = MM(acc, acc); then MUL acc = MM(acc, xm) only if exp[i] = 1.
- POST: result = MM(acc, 1).
REQ-016 SHALL use states IDLE, PRE_X, PRE_ACC, SQR, MUL, POST, DONE, each operation state having an ISSUE and a WAIT phase.
REQ-017 SHALL always process all W exponent bits, with no leading-zero skip; total multiplies = W + 3 + popcount(exp).
REQ-018 In IDLE with go=1 and N[0]=1, SHALL latch base, exp, N, r2 internally, set busy=1 the next cycle, and enter PRE_X/ISSUE.
REQ-019 In IDLE with go=1 and N[0]=0, SHALL pulse err for one cycle, remain in IDLE, keep busy=0, and issue no multiply.
REQ-020 In ISSUE, SHALL present mul_a, mul_b, mul_n stable and drive mul_start_n=0 for exactly one cycle, then move to WAIT.
REQ-021 SHALL hold mul_a, mul_b, mul_n constant from ISSUE until mul_done is sampled high.
REQ-022 In WAIT, mul_done=1 sampled at a posedge SHALL capture mul_out into the destination register, and the next state's ISSUE SHALL occur on the following cycle.
REQ-023 In WAIT, SHALL ignore mul_done on the ISSUE cycle itself and on the first WAIT cycle, to reject a stale done flag.
REQ-024 SHALL count cycles in each WAIT; reaching TMO without mul_done SHALL pulse err, abort, return to IDLE, and set busy=0 with result unchanged.
REQ-025 SHALL use an exponent bit index counter of ceil(log2(W))+1 bits, decremented after each SQR, or after MUL when that bit is set; the transition after index 0 SHALL go to POST.
REQ-026 In DONE, SHALL load result from the POST output, pulse result_valid for one cycle, set busy=0, and return to IDLE on the next cycle.
REQ-027 SHALL ignore go while busy=1, with no queuing.
REQ-028 SHALL hold result until the next successful completion or reset.
REQ-029 SHALL hold mul_start_n=1 in every state and phase other than ISSUE.
REQ-030 SHALL treat all arithmetic as W-bit; the controller performs no arithmetic beyond counters.

Reset
REQ-031 On rst_n=0, asynchronously and at any time including mid-operation, SHALL set state=IDLE, busy=0, result=0, result_valid=0, err=0, mul_start_n=1, mul_a=mul_b=mul_n=0, and clear counters.
REQ-032 After reset release, SHALL accept go no earlier than the first posedge with rst_n=1.

Verification
REQ-033 SHALL use a behavioural MM model with 258-cycle latency for all scenarios.
REQ-034 Scenario: W=256, base=3, exp=5, N=7, correct r2 -> result=5, one result_valid pulse, exactly 261 mul_start_n low pulses.
REQ-035 Scenario: base=9, exp=0, N=11 -> result=1, exactly 259 multiplies.
REQ-036 Scenario: N=10 with go -> err high for exactly one cycle, busy stays 0, mul_start_n never low.
REQ-037 Scenario: model never asserts mul_done after the first issue -> err pulse 512 cycles after the WAIT start, busy falls, result remains 0.
REQ-038 Scenario: rst_n pulsed low during SQR WAIT -> all outputs take REQ-031 values immediately; a following go with base=2, exp=10, N=1009 -> result=15.
REQ-039 Scenario: go reasserted while busy -> no effect, and the first run's result and multiply count are unchanged.
